// File: rtl/led_fader.sv
// led_fader: PWM LED driver that fades linearly toward the blink level.
// Ports: clk, rst (sync, active-high), led_in (target level),
//        led_out (registered PWM), level (brightness), busy (fading).
module led_fader #(
    parameter int PWM_WIDTH = 8,
    parameter int STEP      = 1,
    parameter int FADE_DIV  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 led_in,
    output logic                 led_out,
    output logic [PWM_WIDTH-1:0] level,
    output logic                 busy
);

    localparam int PSW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    localparam logic [PWM_WIDTH-1:0] MAX     = '1;
    localparam logic [PSW-1:0]       PS_LAST = PSW'(FADE_DIV - 1);
    localparam logic [PWM_WIDTH:0]   STEP_W  = (PWM_WIDTH + 1)'(STEP);

    typedef enum logic [1:0] {
        OFF,
        RAMP_UP,
        ON,
        RAMP_DOWN
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic [PSW-1:0]         ps_q;
    logic [PSW-1:0]         ps_d;
    logic [PWM_WIDTH-1:0]   level_d;
    logic [PWM_WIDTH-1:0]   pwm_cnt;
    logic                   tick;
    logic [PWM_WIDTH:0]     sum_up;
    logic [PWM_WIDTH-1:0]   lvl_up;
    logic [PWM_WIDTH-1:0]   lvl_dn;

    assign tick   = (ps_q == PS_LAST);
    // One extra bit so the saturating add never wraps.
    assign sum_up = {1'b0, level} + STEP_W;
    assign lvl_up = (sum_up > {1'b0, MAX}) ? MAX : sum_up[PWM_WIDTH-1:0];
    assign lvl_dn = ({1'b0, level} >= STEP_W)
                  ? (level - STEP_W[PWM_WIDTH-1:0]) : '0;

    assign busy = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

    // A direction change restarts the prescaler and discards any tick
    // due on that same edge, so a led_in toggling every cycle never
    // moves the level.
    always_comb begin
        state_d = state_q;
        ps_d    = ps_q;
        level_d = level;
        unique case (state_q)
            OFF: begin
                if (led_in) begin
                    state_d = RAMP_UP;
                    ps_d    = '0;
                end
            end
            ON: begin
                if (!led_in) begin
                    state_d = RAMP_DOWN;
                    ps_d    = '0;
                end
            end
            RAMP_UP: begin
                if (!led_in) begin
                    state_d = RAMP_DOWN;
                    ps_d    = '0;
                end else if (tick) begin
                    ps_d    = '0;
                    level_d = lvl_up;
                    if (lvl_up == MAX) state_d = ON;
                end else begin
                    ps_d = ps_q + 1'b1;
                end
            end
            RAMP_DOWN: begin
                if (led_in) begin
                    state_d = RAMP_UP;
                    ps_d    = '0;
                end else if (tick) begin
                    ps_d    = '0;
                    level_d = lvl_dn;
                    if (lvl_dn == '0) state_d = OFF;
                end else begin
                    ps_d = ps_q + 1'b1;
                end
            end
            default: begin
                state_d = OFF;
                ps_d    = '0;
                level_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= OFF;
            ps_q    <= '0;
            level   <= '0;
            pwm_cnt <= '0;
            led_out <= 1'b0;
        end else begin
            state_q <= state_d;
            ps_q    <= ps_d;
            level   <= level_d;
            pwm_cnt <= pwm_cnt + 1'b1;
            // MAX term makes full brightness solid rather than 255/256.
            led_out <= (level == MAX) | (pwm_cnt < level);
        end
    end

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed and randomized checks of led_fader against
// a behavioural fade/PWM model.
module tb_led_fader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       led_in = 1'b0;
    logic       led_out;
    logic [7:0] level;
    logic       busy;

    logic       led_in_b = 1'b0;
    logic       led_out_b;
    logic [7:0] level_b;
    logic       busy_b;

    int n_cmp = 0;
    int n_bad = 0;

    led_fader #(.PWM_WIDTH(8), .STEP(16), .FADE_DIV(4)) dut (
        .clk(clk), .rst(rst), .led_in(led_in),
        .led_out(led_out), .level(level), .busy(busy)
    );

    led_fader #(.PWM_WIDTH(8), .STEP(16), .FADE_DIV(1024)) dut_b (
        .clk(clk), .rst(rst), .led_in(led_in_b),
        .led_out(led_out_b), .level(level_b), .busy(busy_b)
    );

    initial forever #5 clk = ~clk;

    // Reference model for dut: brightness moves toward the target by
    // STEP every FADE_DIV edges counted from the last retarget.
    int m_lvl = 0;
    int m_up = 0;
    int m_busy = 0;
    int m_age = 0;
    int m_cyc = 0;
    bit m_led = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_lvl = 0; m_up = 0; m_busy = 0;
            m_age = 0; m_cyc = 0; m_led = 0;
        end else begin
            m_led = (m_lvl == 255) || ((m_cyc % 256) < m_lvl);
            m_cyc++;
            if ((m_busy != 0 && m_up != int'(led_in)) ||
                (m_busy == 0 && m_lvl != (led_in ? 255 : 0))) begin
                m_busy = 1;
                m_up = int'(led_in);
                m_age = 0;
            end else if (m_busy != 0) begin
                m_age++;
                if (m_age % 4 == 0) begin
                    if (m_up != 0) m_lvl = (m_lvl + 16 > 255) ? 255 : m_lvl + 16;
                    else m_lvl = (m_lvl < 16) ? 0 : m_lvl - 16;
                    if (m_lvl == (m_up != 0 ? 255 : 0)) m_busy = 0;
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        led_in = 1'b0;
        led_in_b = 1'b0;
        repeat (5) begin
            @(negedge clk);
            n_cmp++;
            if (level !== 8'd0 || busy !== 1'b0 || led_out !== 1'b0 ||
                level_b !== 8'd0 || busy_b !== 1'b0 || led_out_b !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_hold: level=%0d busy=%b led=%b lvl_b=%0d required 0/0/0/0",
                         level, busy, led_out, level_b);
            end
        end
        rst = 1'b0;
        repeat (300) begin
            @(negedge clk);
            n_cmp++;
            if (level !== 8'd0 || busy !== 1'b0 || led_out !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle: level=%0d busy=%b led=%b required 0/0/0",
                         level, busy, led_out);
            end
        end
    endtask

    task automatic test_rise();
        int exp;
        led_in = 1'b1;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            exp = 16 * (c / 4);
            if (exp > 255) exp = 255;
            n_cmp++;
            if (level !== 8'(exp) || busy !== (c < 64)) begin
                n_bad++;
                $display("FAIL rise c=%0d: level=%0d busy=%b required %0d/%b",
                         c, level, busy, exp, c < 64);
            end
            if (c >= 65) begin
                n_cmp++;
                if (led_out !== 1'b1) begin
                    n_bad++;
                    $display("FAIL rise_on_led c=%0d: led=%b required 1", c, led_out);
                end
            end
        end
    endtask

    task automatic test_fall();
        int exp;
        led_in = 1'b0;
        for (int c = 0; c <= 70; c++) begin
            @(negedge clk);
            exp = 255 - 16 * (c / 4);
            if (exp < 0) exp = 0;
            n_cmp++;
            if (level !== 8'(exp) || busy !== (c < 64)) begin
                n_bad++;
                $display("FAIL fall c=%0d: level=%0d busy=%b required %0d/%b",
                         c, level, busy, exp, c < 64);
            end
            if (c >= 65) begin
                n_cmp++;
                if (led_out !== 1'b0) begin
                    n_bad++;
                    $display("FAIL fall_off_led c=%0d: led=%b required 0", c, led_out);
                end
            end
        end
    endtask

    task automatic test_reversal();
        int exp;
        int prev;
        bit seen;
        seen = 0;
        led_in = 1'b1;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            n_cmp++;
            if (level > 8'd80) begin
                n_bad++;
                $display("FAIL rev_peak: level=%0d required <=80", level);
            end
            if (level == 8'd80) seen = 1;
        end
        if (!seen) begin
            n_bad++;
            $display("FAIL rev_timeout: level=%0d required 80", level);
        end
        led_in = 1'b0;
        prev = 80;
        for (int c = 0; c <= 30; c++) begin
            @(negedge clk);
            exp = 80 - 16 * (c / 4);
            if (exp < 0) exp = 0;
            n_cmp++;
            if (level !== 8'(exp) || busy !== (c < 20) ||
                int'(level) > prev || prev - int'(level) > 16) begin
                n_bad++;
                $display("FAIL rev_down c=%0d: level=%0d busy=%b required %0d/%b",
                         c, level, busy, exp, c < 20);
            end
            prev = int'(level);
        end
    endtask

    task automatic test_mid_reset();
        bit seen;
        seen = 0;
        led_in = 1'b1;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (level == 8'd128) seen = 1;
        end
        n_cmp++;
        if (!seen || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_timeout: level=%0d busy=%b required 128/1", level, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (level !== 8'd0 || led_out !== 1'b0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset: level=%0d busy=%b led=%b required 0/0/0",
                     level, busy, led_out);
        end
        rst = 1'b0;
        for (int c = 0; c <= 4; c++) begin
            @(negedge clk);
            n_cmp++;
            if (level !== ((c == 4) ? 8'd16 : 8'd0) || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL mid_restart c=%0d: level=%0d busy=%b required %0d/1",
                         c, level, busy, (c == 4) ? 16 : 0);
            end
        end
        led_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (busy == 1'b0) seen = 1;
        end
        n_cmp++;
        if (!seen || level !== 8'd0) begin
            n_bad++;
            $display("FAIL mid_drain: level=%0d busy=%b required 0/0", level, busy);
        end
    endtask

    task automatic test_toggle();
        bit seen;
        for (int i = 0; i < 50; i++) begin
            led_in = ~led_in;
            @(negedge clk);
            n_cmp++;
            if (level !== 8'd0 || busy !== 1'b1) begin
                n_bad++;
                $display("FAIL toggle i=%0d: level=%0d busy=%b required 0/1",
                         i, level, busy);
            end
        end
        led_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (busy == 1'b0) seen = 1;
        end
        n_cmp++;
        if (!seen || level !== 8'd0) begin
            n_bad++;
            $display("FAIL toggle_settle: level=%0d busy=%b required 0/0", level, busy);
        end
    endtask

    task automatic test_pwm_duty();
        int cnt;
        bit seen;
        int tgt;
        led_in_b = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            tgt = 16 * k;
            seen = 0;
            for (int i = 0; i < 2500 && !seen; i++) begin
                @(negedge clk);
                if (int'(level_b) == tgt) seen = 1;
            end
            repeat (2) @(negedge clk);
            cnt = 0;
            repeat (256) begin
                @(negedge clk);
                cnt += int'(led_out_b);
            end
            n_cmp++;
            if (!seen || cnt != tgt || int'(level_b) != tgt) begin
                n_bad++;
                $display("FAIL pwm_duty_%0d: highs=%0d level=%0d required %0d",
                         tgt, cnt, level_b, tgt);
            end
        end
        led_in_b = 1'b0;
    endtask

    task automatic test_random();
        int hold;
        int done;
        done = 0;
        while (done < 3000) begin
            if ($urandom_range(0, 3) == 0) hold = $urandom_range(1, 3);
            else hold = $urandom_range(4, 90);
            led_in = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 24) == 0);
            repeat (hold) begin
                @(negedge clk);
                rst = 1'b0;
                done++;
                n_cmp++;
                if (level !== 8'(m_lvl) || busy !== (m_busy != 0) ||
                    led_out !== m_led) begin
                    n_bad++;
                    $display("FAIL random t=%0t: level=%0d busy=%b led=%b required %0d/%0d/%b",
                             $time, level, busy, led_out, m_lvl, m_busy, m_led);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: run did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_rise();
        test_fall();
        test_reversal();
        test_mid_reset();
        test_toggle();
        test_pwm_duty();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
